softmax_ctrl: RTL
=================

# softmax_ctrl

Top-level sequencer for the softmax engine. It drives the shared `state` code and the `counter_ifm` and `counter_compute` buses that the exponent unit, accumulator, divider and output write stage decode. Each frame runs in this order: load `OUTPUT_SIZE` inputs, run exponentials with accumulation, divide, then hand off to the write stage. It sits between the host-side start/stream handshake and the softmax datapath.

## Interface
- `DATA_WIDTH`, 24: datapath word width; passed through to the package, no logic here.
- `OUTPUT_SIZE`, 10: elements per frame (2..255).
- `EXP_LAT`, 4: exponent-unit pipeline latency in cycles (1..15).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: frame request; sampled only in IDLE.
- `in_valid` in 1: input element valid.
- `in_ready` out 1: high only in LOAD.
- `div_done` in 1: divider finished; single-cycle pulse.
- `state` out 4: phase code consumed by the datapath and the write stage.
- `counter_ifm` out 16: per-phase index counter.
- `counter_compute` out 8: completed-frame count, saturating.
- `exp_en` out 1: issue one exponent operation.
- `acc_clr` out 1: clear the sum accumulator.
- `acc_en` out 1: accumulate one exponent result.
- `div_start` out 1: single-cycle divider launch.
- `busy` out 1: not in IDLE.
- `done` out 1: single-cycle end-of-frame pulse.

## Operation
- State codes, 4-bit: IDLE=0, LOAD=1, EXP=2, DIV=4, WRITE=5, DONE=6. Codes 3 and 7..15 are unused and decode to IDLE on the next cycle.
- **IDLE**
  - `start`=1 → LOAD.
  - `acc_clr` pulses in the same cycle the transition to LOAD is taken.
- **LOAD**
  - `in_ready`=1.
  - Each `in_valid` increments `counter_ifm`, starting from 0.
  - When the count reaches `OUTPUT_SIZE` → EXP, and `counter_ifm` is cleared.
- **EXP**
  - Lasts `OUTPUT_SIZE+EXP_LAT` cycles; `counter_ifm` counts these cycles from 0.
  - `exp_en`=1 while `counter_ifm` < `OUTPUT_SIZE`.
  - `acc_en`=1 while `EXP_LAT` ≤ `counter_ifm` < `EXP_LAT+OUTPUT_SIZE`.
  - On the last cycle → DIV.
- **DIV**
  - `div_start`=1 on the first cycle only.
  - Waits for `div_done`; `div_done` → WRITE.
  - A `div_done` arriving on the `div_start` cycle is honoured.
- **WRITE**
  - `counter_compute` increments on entry, saturating at 255.
  - `counter_ifm` is 1 on the first cycle and increments each cycle. The write stage triggers on `state`=5, `counter_ifm`=1, `counter_compute`>0.
  - Holds for `OUTPUT_SIZE+2` cycles, so the write stage can sweep `sel_data` 1..`OUTPUT_SIZE` and return idle; then → DONE.
- **DONE**
  - One cycle with `done`=1 → IDLE; `counter_ifm` is cleared.
- `start` outside IDLE is ignored.
- `in_valid` outside LOAD is ignored.
- `div_done` outside DIV is ignored.
- All outputs are registered.

## Timing
- Reset values:
  - `state`=0.
  - All counters 0.
  - `in_ready`, `exp_en`, `acc_en`, `acc_clr`, `div_start`, `busy`, `done` = 0.
  - `counter_compute` is cleared only by reset.
- Reset assertion mid-frame forces IDLE asynchronously. No `done` is produced for the aborted frame.
- Timing from `start`:
  - `start` at cycle t → `state`=1 and `in_ready`=1 at t+1.
  - With `in_valid` held high, the last input is accepted at t+`OUTPUT_SIZE`.
  - EXP starts at t+`OUTPUT_SIZE`+1.
- Minimum frame latency from `start` to `done`, with zero-wait divider (`div_done` on the `div_start` cycle): 1 + `OUTPUT_SIZE` + (`OUTPUT_SIZE`+`EXP_LAT`) + 1 + (`OUTPUT_SIZE`+2) + 1 cycles.
- `start` asserted in the DONE cycle is ignored. A new frame needs `start` in IDLE, one cycle later.

## Configuration
- `SOFTMAX_CTRL_PERF_EN` defined:
  - Adds output `perf_cycles` [31:0], the cycle count from `start` acceptance to `done` of the last frame.
  - Updated on the `done` cycle; reset to 0; saturates at all-ones.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `softmax_pkg`:
  - State code localparams (IDLE..DONE).
  - Widths: `STATE_W`=4, `IFM_CNT_W`=16, `CMP_CNT_W`=8.
  - `DATA_WIDTH` default.
- One sub-module `phase_counter`: a loadable up-counter with clear, enable, and a terminal-count compare against a runtime limit. One instance drives `counter_ifm` for all phases.

## Test plan
- **Basic frame** (`OUTPUT_SIZE`=10, `EXP_LAT`=4):
  - Stimulus: `start`, 10 back-to-back `in_valid`, `div_done` 3 cycles after `div_start`.
  - Required: `exp_en` high 10 cycles; `acc_en` high 10 cycles starting 4 cycles later; WRITE lasts 12 cycles with `counter_ifm` 1..12; `counter_compute`=1; one `done` pulse.
- **Gapped input:** `in_valid` toggling every other cycle → LOAD lasts 20 cycles; `in_ready` high throughout; exactly 10 inputs accepted.
- **Ignored requests:** `start` pulses during EXP and WRITE → no restart, and frame timing identical to the basic frame.
- **Counter saturation:** 260 consecutive frames → `counter_compute` reads 255 from frame 255 onward.
- **Reset mid-frame:** `rst_n` asserted in DIV → `state`=0 and `busy`=0 immediately; after release, a new `start` runs a full frame; `counter_compute` restarts from 1.
- **Perf counter** (`SOFTMAX_CTRL_PERF_EN`): basic frame → `perf_cycles` equals the measured `start`-to-`done` distance; without the macro, the port is absent.

Source files
------------

// File: rtl/softmax_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : softmax_pkg
// Description : Shared widths, state codes and helpers for the softmax engine
//               sequencer and the datapath blocks that decode its buses.
// Revision    : 1.0 - initial release
// ============================================================================
package softmax_pkg;

  // Default datapath word width for the engine
  localparam int unsigned DATA_WIDTH_DEFAULT = 24;

  // Bus widths
  localparam int unsigned STATE_W   = 4;
  localparam int unsigned IFM_CNT_W = 16;
  localparam int unsigned CMP_CNT_W = 8;

  // Phase codes seen by the exponent unit, accumulator, divider, write stage
  localparam logic [STATE_W-1:0] ST_IDLE  = 4'd0;
  localparam logic [STATE_W-1:0] ST_LOAD  = 4'd1;
  localparam logic [STATE_W-1:0] ST_EXP   = 4'd2;
  localparam logic [STATE_W-1:0] ST_DIV   = 4'd4;
  localparam logic [STATE_W-1:0] ST_WRITE = 4'd5;
  localparam logic [STATE_W-1:0] ST_DONE  = 4'd6;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_EXP   = ST_EXP,
    S_DIV   = ST_DIV,
    S_WRITE = ST_WRITE,
    S_DONE  = ST_DONE
  } state_t;

  // Saturating increment of the completed-frame counter
  function automatic logic [CMP_CNT_W-1:0] cmp_sat_inc(input logic [CMP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/softmax_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : softmax_ctrl_if
// Description : Host handshake and datapath control bundle of the softmax
//               sequencer. perf_cycles exists only with SOFTMAX_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface softmax_ctrl_if;
  import softmax_pkg::*;

  // Host side
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic                 div_done;
  // Datapath control
  logic [STATE_W-1:0]   state;
  logic [IFM_CNT_W-1:0] counter_ifm;
  logic [CMP_CNT_W-1:0] counter_compute;
  logic                 exp_en;
  logic                 acc_clr;
  logic                 acc_en;
  logic                 div_start;
  logic                 busy;
  logic                 done;
`ifdef SOFTMAX_CTRL_PERF_EN
  logic [31:0]          perf_cycles;
`endif

  // Host / datapath view
  modport master (
    output start, in_valid, div_done,
`ifdef SOFTMAX_CTRL_PERF_EN
    input  perf_cycles,
`endif
    input  in_ready, state, counter_ifm, counter_compute, exp_en, acc_clr,
           acc_en, div_start, busy, done
  );

  // Sequencer view
  modport slave (
    input  start, in_valid, div_done,
`ifdef SOFTMAX_CTRL_PERF_EN
    output perf_cycles,
`endif
    output in_ready, state, counter_ifm, counter_compute, exp_en, acc_clr,
           acc_en, div_start, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/softmax_ctrl_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : phase_counter
// Description : Loadable up-counter with clear and enable, plus a terminal
//               count flag comparing the current value against a runtime
//               limit. Also exposes the next value so callers can register
//               decodes that line up with the counter.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_clr,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_val,
  input  wire logic             i_en,
  input  wire logic [WIDTH-1:0] i_limit,
  output logic      [WIDTH-1:0] o_count,
  output logic      [WIDTH-1:0] o_count_nxt,
  output logic                  o_tc
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;

  // Next value: clear beats load beats increment
  always_comb begin
    w_count_nxt = r_count;
    if (i_clr) begin
      w_count_nxt = '0;
    end else if (i_load) begin
      w_count_nxt = i_load_val;
    end else if (i_en) begin
      w_count_nxt = r_count + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_count     = r_count;
  assign o_count_nxt = w_count_nxt;
  assign o_tc        = (r_count == i_limit);

endmodule
`default_nettype wire

// File: rtl/softmax_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : softmax_ctrl
// Description : Frame sequencer for the softmax engine: LOAD -> EXP -> DIV ->
//               WRITE -> DONE. Drives the shared state code plus the
//               counter_ifm / counter_compute buses; every output registered.
//               Optional feature macro: SOFTMAX_CTRL_PERF_EN adds the
//               perf_cycles start-to-done counter.
// Revision    : 1.0 - initial release
// ============================================================================
module softmax_ctrl
  import softmax_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = softmax_pkg::DATA_WIDTH_DEFAULT,
  parameter int unsigned OUTPUT_SIZE = 10,
  parameter int unsigned EXP_LAT     = 4
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  softmax_ctrl_if.slave bus
);

  // Phase limits, expressed in counter_ifm units
  localparam logic [IFM_CNT_W-1:0] c_LOAD_LAST  = IFM_CNT_W'(OUTPUT_SIZE - 1);
  localparam logic [IFM_CNT_W-1:0] c_EXP_LAST   = IFM_CNT_W'(OUTPUT_SIZE + EXP_LAT - 1);
  localparam logic [IFM_CNT_W-1:0] c_WRITE_LAST = IFM_CNT_W'(OUTPUT_SIZE + 2);
  localparam logic [IFM_CNT_W-1:0] c_EXP_ISSUE  = IFM_CNT_W'(OUTPUT_SIZE);
  localparam logic [IFM_CNT_W-1:0] c_ACC_FIRST  = IFM_CNT_W'(EXP_LAT);
  localparam logic [IFM_CNT_W-1:0] c_ACC_END    = IFM_CNT_W'(EXP_LAT + OUTPUT_SIZE);
  localparam logic [IFM_CNT_W-1:0] c_WRITE_FIRST = IFM_CNT_W'(1);

  // Reject out-of-range configurations at elaboration
  if (OUTPUT_SIZE < 2 || OUTPUT_SIZE > 255) begin : g_bad_output_size
    $error("softmax_ctrl: OUTPUT_SIZE must be within 2..255");
  end
  if (EXP_LAT < 1 || EXP_LAT > 15) begin : g_bad_exp_lat
    $error("softmax_ctrl: EXP_LAT must be within 1..15");
  end
  if (DATA_WIDTH == 0) begin : g_bad_data_width
    $error("softmax_ctrl: DATA_WIDTH must be non-zero");
  end

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 w_cnt_clr;
  logic                 w_cnt_load;
  logic                 w_cnt_en;
  logic [IFM_CNT_W-1:0] w_cnt_limit;
  logic [IFM_CNT_W-1:0] w_cnt;
  logic [IFM_CNT_W-1:0] w_cnt_nxt;
  logic                 w_cnt_tc;

  logic                 r_in_ready;
  logic                 r_exp_en;
  logic                 r_acc_en;
  logic                 r_acc_clr;
  logic                 r_div_start;
  logic                 r_busy;
  logic                 r_done;
  logic [CMP_CNT_W-1:0] r_cmp;

  // Shared index counter for every phase
  phase_counter #(
    .WIDTH (IFM_CNT_W)
  ) u_phase_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_cnt_clr),
    .i_load      (w_cnt_load),
    .i_load_val  (c_WRITE_FIRST),
    .i_en        (w_cnt_en),
    .i_limit     (w_cnt_limit),
    .o_count     (w_cnt),
    .o_count_nxt (w_cnt_nxt),
    .o_tc        (w_cnt_tc)
  );

  // Next state and counter control for the current phase
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_en    = 1'b0;
    w_cnt_limit = c_LOAD_LAST;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (bus.start) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_cnt_limit = c_LOAD_LAST;
        if (bus.in_valid) begin
          if (w_cnt_tc) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_EXP;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
      end
      S_EXP: begin
        w_cnt_limit = c_EXP_LAST;
        if (w_cnt_tc) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_DIV;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      S_DIV: begin
        // counter_ifm enters WRITE at 1 so the write stage trigger lines up
        if (bus.div_done) begin
          w_cnt_load  = 1'b1;
          w_state_nxt = S_WRITE;
        end else begin
          w_cnt_clr = 1'b1;
        end
      end
      S_WRITE: begin
        w_cnt_limit = c_WRITE_LAST;
        if (w_cnt_tc) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      S_DONE: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered control strobes, decoded from next state and next count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_exp_en    <= 1'b0;
      r_acc_en    <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_div_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_LOAD);
      r_exp_en    <= (w_state_nxt == S_EXP) && (w_cnt_nxt < c_EXP_ISSUE);
      r_acc_en    <= (w_state_nxt == S_EXP) && (w_cnt_nxt >= c_ACC_FIRST) &&
                     (w_cnt_nxt < c_ACC_END);
      r_acc_clr   <= (r_state == S_IDLE) && bus.start;
      r_div_start <= (w_state_nxt == S_DIV) && (r_state != S_DIV);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  // Completed-frame count, bumped on WRITE entry; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp <= '0;
    end else if ((w_state_nxt == S_WRITE) && (r_state != S_WRITE)) begin
      r_cmp <= cmp_sat_inc(r_cmp);
    end
  end

  assign bus.state           = r_state;
  assign bus.counter_ifm     = w_cnt;
  assign bus.counter_compute = r_cmp;
  assign bus.in_ready        = r_in_ready;
  assign bus.exp_en          = r_exp_en;
  assign bus.acc_en          = r_acc_en;
  assign bus.acc_clr         = r_acc_clr;
  assign bus.div_start       = r_div_start;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;

`ifdef SOFTMAX_CTRL_PERF_EN
  logic [31:0] r_perf_run;
  logic [31:0] r_perf_cycles;
  logic [31:0] w_perf_inc;

  assign w_perf_inc = (&r_perf_run) ? r_perf_run : r_perf_run + 32'd1;

  // Running frame age (cycles since the start cycle) and its capture at DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_run    <= '0;
      r_perf_cycles <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        r_perf_run <= 32'd1;
      end else begin
        r_perf_run <= w_perf_inc;
      end
      if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
        r_perf_cycles <= w_perf_inc;
      end
    end
  end

  assign bus.perf_cycles = r_perf_cycles;
`endif

endmodule
`default_nettype wire
